// File: rtl/mem_io_responder.sv
// mem_io_responder
// Memory-stage responder for the memory-mapped I/O window. Decodes the
// EXE/MEM address, answers loads combinationally, performs stores into
// three output ports, synchronizes two switch inputs and keeps a sticky
// input-change flag readable (and read-cleared) through a status word.
//
// Optional feature: define MEM_IO_TIMER_EN to add a 32-bit free-running
// cycle counter at word offset 6 (loadable by a store). Without it, offset 6
// reads 0 and stores to it are ignored.
//
// Word map (offset = malu[4:2]):
//   0 in_port0 (sync, RO)   1 in_port1 (sync, RO)
//   2 out_port0 (RW)        3 out_port1 (RW)      4 out_port2 (RW)
//   5 status {31'b0, chg}   6 timer (RO/loadable)  7 reserved (reads 0)
module mem_io_responder #(
    parameter int unsigned IN_WIDTH = 10,
    parameter logic [7:0]  IO_BASE  = 8'h80
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [31:0]         malu,
    input  logic [31:0]         mb,
    input  logic                mwmem,
    input  logic                mm2reg,
    input  logic [IN_WIDTH-1:0] in_port0,
    input  logic [IN_WIDTH-1:0] in_port1,
    output logic [31:0]         out_port0,
    output logic [31:0]         out_port1,
    output logic [31:0]         out_port2,
    output logic                io_sel,
    output logic [31:0]         io_rdata
);

    localparam logic [2:0] OFF_IN0  = 3'd0;
    localparam logic [2:0] OFF_IN1  = 3'd1;
    localparam logic [2:0] OFF_OUT0 = 3'd2;
    localparam logic [2:0] OFF_OUT1 = 3'd3;
    localparam logic [2:0] OFF_OUT2 = 3'd4;
    localparam logic [2:0] OFF_STAT = 3'd5;
    localparam logic [2:0] OFF_TMR  = 3'd6;

    logic [2:0]          offset_s;
    logic                wr_s;
    logic                clr_chg_s;
    logic                set_chg_s;
    logic [31:0]         timer_s;
    logic                chg_r;
    logic [IN_WIDTH-1:0] s1_0_r;
    logic [IN_WIDTH-1:0] s2_0_r;
    logic [IN_WIDTH-1:0] s3_0_r;
    logic [IN_WIDTH-1:0] s1_1_r;
    logic [IN_WIDTH-1:0] s2_1_r;
    logic [IN_WIDTH-1:0] s3_1_r;

    // Only address bits [7:2] take part in decoding; fold the rest away.
    logic unused_s;
    assign unused_s = ^{malu[31:8], malu[1:0]};

    // Address decode, store enable and change-flag set/clear conditions.
    always_comb begin
        io_sel    = ((malu[7:0] & 8'hE0) == IO_BASE);
        offset_s  = malu[4:2];
        wr_s      = mwmem & io_sel;
        clr_chg_s = mm2reg & io_sel & (offset_s == OFF_STAT);
        set_chg_s = (s2_0_r != s3_0_r) | (s2_1_r != s3_1_r);
    end

    // Load data mux; zero outside the window, reserved offset reads zero.
    always_comb begin
        io_rdata = 32'h0;
        if (io_sel) begin
            case (offset_s)
                OFF_IN0:  io_rdata = 32'(s2_0_r);
                OFF_IN1:  io_rdata = 32'(s2_1_r);
                OFF_OUT0: io_rdata = out_port0;
                OFF_OUT1: io_rdata = out_port1;
                OFF_OUT2: io_rdata = out_port2;
                OFF_STAT: io_rdata = {31'h0, chg_r};
                OFF_TMR:  io_rdata = timer_s;
                default:  io_rdata = 32'h0;
            endcase
        end else begin
            io_rdata = 32'h0;
        end
    end

    // Output port registers written by in-window stores to offsets 2..4.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_port0 <= 32'h0;
            out_port1 <= 32'h0;
            out_port2 <= 32'h0;
        end else if (wr_s) begin
            case (offset_s)
                OFF_OUT0: out_port0 <= mb;
                OFF_OUT1: out_port1 <= mb;
                OFF_OUT2: out_port2 <= mb;
                default:  ;
            endcase
        end
    end

    // Two-flop synchronizers plus a history stage used for change detection.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_0_r <= '0;
            s2_0_r <= '0;
            s3_0_r <= '0;
            s1_1_r <= '0;
            s2_1_r <= '0;
            s3_1_r <= '0;
        end else begin
            s1_0_r <= in_port0;
            s2_0_r <= s1_0_r;
            s3_0_r <= s2_0_r;
            s1_1_r <= in_port1;
            s2_1_r <= s1_1_r;
            s3_1_r <= s2_1_r;
        end
    end

    // Sticky change flag; a new change beats a simultaneous status read-clear.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            chg_r <= 1'b0;
        end else if (set_chg_s) begin
            chg_r <= 1'b1;
        end else if (clr_chg_s) begin
            chg_r <= 1'b0;
        end else begin
            chg_r <= chg_r;
        end
    end

`ifdef MEM_IO_TIMER_EN
    logic [31:0] timer_r;

    // Free-running cycle counter, loadable by a store to offset 6.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            timer_r <= 32'h0;
        end else if (wr_s && (offset_s == OFF_TMR)) begin
            timer_r <= mb;
        end else begin
            timer_r <= timer_r + 32'h1;
        end
    end

    assign timer_s = timer_r;
`else
    assign timer_s = 32'h0;
`endif

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder. Expected values are pushed to a
// scoreboard queue as stimulus is driven and popped when the DUT output is
// sampled (1 time unit after driving, well away from the rising edge).
module tb_mem_io_responder;

    logic        clock;
    logic        clk_en;
    logic        resetn;
    logic [31:0] malu;
    logic [31:0] mb;
    logic        mwmem;
    logic        mm2reg;
    logic [9:0]  in_port0;
    logic [9:0]  in_port1;
    logic [31:0] out_port0;
    logic [31:0] out_port1;
    logic [31:0] out_port2;
    logic        io_sel;
    logic [31:0] io_rdata;

    int          checks;
    int          errors;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    mem_io_responder #(.IN_WIDTH(10), .IO_BASE(8'h80)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .malu     (malu),
        .mb       (mb),
        .mwmem    (mwmem),
        .mm2reg   (mm2reg),
        .in_port0 (in_port0),
        .in_port1 (in_port1),
        .out_port0(out_port0),
        .out_port1(out_port1),
        .out_port2(out_port2),
        .io_sel   (io_sel),
        .io_rdata (io_rdata)
    );

    always #5 if (clk_en) clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        mwmem  = 1'b0;
        mm2reg = 1'b0;
        malu   = 32'h0;
        mb     = 32'h0;
    endtask

    task automatic test_reset();
        clock = 1'b0; clk_en = 1'b0; resetn = 1'b1;
        in_port0 = 10'h0; in_port1 = 10'h0;
        idle();
        #2 resetn = 1'b0;
        #2;
        exp_q.push_back(32'h0);
        e = exp_q.pop_front(); checks++;
        if (out_port0 !== e) begin errors++; $display("FAIL reset_out0 got %h exp %h", out_port0, e); end
        exp_q.push_back(32'h0);
        e = exp_q.pop_front(); checks++;
        if (out_port1 !== e) begin errors++; $display("FAIL reset_out1 got %h exp %h", out_port1, e); end
        exp_q.push_back(32'h0);
        e = exp_q.pop_front(); checks++;
        if (out_port2 !== e) begin errors++; $display("FAIL reset_out2 got %h exp %h", out_port2, e); end
        malu = 32'h94; exp_q.push_back(32'h0); #1;
        e = exp_q.pop_front(); checks++;
        if (io_rdata !== e) begin errors++; $display("FAIL reset_chg got %h exp %h", io_rdata, e); end
        clk_en = 1'b1;
        tick(); tick();
        resetn = 1'b1;
        tick();
        malu = 32'h94; mm2reg = 1'b1; exp_q.push_back(32'h0); #1;
        e = exp_q.pop_front(); checks++;
        if (io_rdata !== e) begin errors++; $display("FAIL post_reset_status got %h exp %h", io_rdata, e); end
        tick(); idle();
    endtask

    task automatic test_store();
        malu = 32'h88; mb = 32'h0000_ABCD; mwmem = 1'b1;
        exp_q.push_back(32'h0000_ABCD);
        tick(); idle();
        e = exp_q.pop_front(); checks++;
        if (out_port0 !== e) begin errors++; $display("FAIL store_out0 got %h exp %h", out_port0, e); end
        malu = 32'h88; mm2reg = 1'b1; exp_q.push_back(32'h0000_ABCD); #1;
        e = exp_q.pop_front(); checks++;
        if (io_rdata !== e) begin errors++; $display("FAIL load_out0 got %h exp %h", io_rdata, e); end
        tick(); idle();
        // Low address bits ignored, upper bits not decoded: writes out_port1.
        malu = 32'h1234_568F; mb = 32'h1234_5678; mwmem = 1'b1;
        exp_q.push_back(32'h1234_5678);
        tick(); idle();
        e = exp_q.pop_front(); checks++;
        if (out_port1 !== e) begin errors++; $display("FAIL store_out1 got %h exp %h", out_port1, e); end
        malu = 32'h90; mb = 32'hCAFE_F00D; mwmem = 1'b1;
        exp_q.push_back(32'hCAFE_F00D);
        tick(); idle();
        e = exp_q.pop_front(); checks++;
        if (out_port2 !== e) begin errors++; $display("FAIL store_out2 got %h exp %h", out_port2, e); end
        malu = 32'h8C; exp_q.push_back(32'h1234_5678); #1;
        e = exp_q.pop_front(); checks++;
        if (io_rdata !== e) begin errors++; $display("FAIL load_out1 got %h exp %h", io_rdata, e); end
        // Stores to read-only and reserved offsets change nothing.
        for (int i = 0; i < 3; i++) begin
            malu = (i == 0) ? 32'h80 : ((i == 1) ? 32'h94 : 32'h9C);
            mb = 32'hDEAD_BEEF; mwmem = 1'b1;
            tick(); idle();
            exp_q.push_back({out_port0 === 32'h0000_ABCD, out_port1 === 32'h1234_5678,
                             out_port2 === 32'hCAFE_F00D, 29'h0});
            e = exp_q.pop_front(); checks++;
            if (e !== 32'hE000_0000) begin
                errors++;
                $display("FAIL ro_store_%0d ports %h %h %h exp %h %h %h", i, out_port0, out_port1,
                         out_port2, 32'h0000_ABCD, 32'h1234_5678, 32'hCAFE_F00D);
            end
        end
        malu = 32'h9C; exp_q.push_back(32'h0); #1;
        e = exp_q.pop_front(); checks++;
        if (io_rdata !== e) begin errors++; $display("FAIL reserved_read got %h exp %h", io_rdata, e); end
    endtask

    task automatic test_out_of_window();
        for (int i = 0; i < 2; i++) begin
            malu = (i == 0) ? 32'h08 : 32'hA8; mb = 32'hFFFF_FFFF; mwmem = 1'b1; mm2reg = 1'b1;
            exp_q.push_back(32'h0); #1;
            e = exp_q.pop_front(); checks++;
            if ({31'h0, io_sel} !== e) begin errors++; $display("FAIL oow_sel_%0d got %b exp 0", i, io_sel); end
            exp_q.push_back(32'h0);
            e = exp_q.pop_front(); checks++;
            if (io_rdata !== e) begin errors++; $display("FAIL oow_rdata_%0d got %h exp %h", i, io_rdata, e); end
            tick(); idle();
            exp_q.push_back(32'h0000_ABCD);
            e = exp_q.pop_front(); checks++;
            if (out_port0 !== e) begin errors++; $display("FAIL oow_out0_%0d got %h exp %h", i, out_port0, e); end
            exp_q.push_back(32'hCAFE_F00D);
            e = exp_q.pop_front(); checks++;
            if (out_port2 !== e) begin errors++; $display("FAIL oow_out2_%0d got %h exp %h", i, out_port2, e); end
        end
    endtask

    task automatic test_input_chg();
        in_port1 = 10'h155; malu = 32'h84;
        tick();
        exp_q.push_back(32'h0); #1;
        e = exp_q.pop_front(); checks++;
        if (io_rdata !== e) begin errors++; $display("FAIL in1_edge1 got %h exp %h", io_rdata, e); end
        tick();
        exp_q.push_back(32'h0000_0155); #1;
        e = exp_q.pop_front(); checks++;
        if (io_rdata !== e) begin errors++; $display("FAIL in1_edge2 got %h exp %h", io_rdata, e); end
        malu = 32'h94; exp_q.push_back(32'h0); #1;
        e = exp_q.pop_front(); checks++;
        if (io_rdata !== e) begin errors++; $display("FAIL chg_edge2 got %h exp %h", io_rdata, e); end
        tick();
        exp_q.push_back(32'h1); #1;
        e = exp_q.pop_front(); checks++;
        if (io_rdata !== e) begin errors++; $display("FAIL chg_edge3 got %h exp %h", io_rdata, e); end
        mm2reg = 1'b1; exp_q.push_back(32'h1); #1;
        e = exp_q.pop_front(); checks++;
        if (io_rdata !== e) begin errors++; $display("FAIL chg_clear_cycle got %h exp %h", io_rdata, e); end
        tick();
        exp_q.push_back(32'h0); #1;
        e = exp_q.pop_front(); checks++;
        if (io_rdata !== e) begin errors++; $display("FAIL chg_after_clear got %h exp %h", io_rdata, e); end
        tick(); idle();
    endtask

    task automatic test_collision();
        in_port0 = 10'h3FF;
        tick(); tick();
        // Next edge sees s2 != s3 while a status load is active.
        malu = 32'h94; mm2reg = 1'b1; exp_q.push_back(32'h0); #1;
        e = exp_q.pop_front(); checks++;
        if (io_rdata !== e) begin errors++; $display("FAIL coll_before got %h exp %h", io_rdata, e); end
        tick();
        mm2reg = 1'b0; exp_q.push_back(32'h1); #1;
        e = exp_q.pop_front(); checks++;
        if (io_rdata !== e) begin errors++; $display("FAIL coll_set_wins got %h exp %h", io_rdata, e); end
        malu = 32'h80; exp_q.push_back(32'h0000_03FF); #1;
        e = exp_q.pop_front(); checks++;
        if (io_rdata !== e) begin errors++; $display("FAIL in0_read got %h exp %h", io_rdata, e); end
        // Both strobes at status: read side effect clears, store ignored.
        malu = 32'h94; mm2reg = 1'b1; mwmem = 1'b1; mb = 32'hFFFF_FFFF;
        tick(); idle();
        malu = 32'h94; exp_q.push_back(32'h0); #1;
        e = exp_q.pop_front(); checks++;
        if (io_rdata !== e) begin errors++; $display("FAIL both_strobe_clear got %h exp %h", io_rdata, e); end
        // Both strobes at an output port: store performed.
        malu = 32'h88; mm2reg = 1'b1; mwmem = 1'b1; mb = 32'h0BAD_CAFE;
        exp_q.push_back(32'h0BAD_CAFE);
        tick(); idle();
        e = exp_q.pop_front(); checks++;
        if (out_port0 !== e) begin errors++; $display("FAIL both_strobe_store got %h exp %h", out_port0, e); end
    endtask

    task automatic test_timer();
        malu = 32'h98; mb = 32'hFFFF_FFFE; mwmem = 1'b1;
        tick(); idle(); malu = 32'h98;
`ifdef MEM_IO_TIMER_EN
        exp_q.push_back(32'hFFFF_FFFE);
        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'h0000_0000);
`else
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
`endif
        for (int i = 0; i < 3; i++) begin
            #1;
            e = exp_q.pop_front(); checks++;
            if (io_rdata !== e) begin errors++; $display("FAIL timer_%0d got %h exp %h", i, io_rdata, e); end
            tick();
        end
        idle();
    endtask

    task automatic test_mid_reset();
        malu = 32'h8C; mb = 32'h5555_5555; mwmem = 1'b1;
        #2 resetn = 1'b0;
        #1;
        exp_q.push_back(32'h0);
        e = exp_q.pop_front(); checks++;
        if (out_port1 !== e) begin errors++; $display("FAIL midreset_async got %h exp %h", out_port1, e); end
        tick();
        resetn = 1'b1; idle();
        tick();
        exp_q.push_back(32'h0);
        e = exp_q.pop_front(); checks++;
        if (out_port1 !== e) begin errors++; $display("FAIL midreset_discard got %h exp %h", out_port1, e); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_store();
        test_out_of_window();
        test_input_chg();
        test_collision();
        test_timer();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
